// File: rtl/ceespu_store_queue_if.sv
// Store-queue bus: execute-stage store request, queue status, and the memory write port.
// The queue itself connects through the slave modport; the pipeline/memory side uses master.
interface ceespu_store_queue_if #(
   parameter int DEPTH = 4
);
   logic                     I_valid;
   logic [13:0]              I_addr;
   logic [31:0]              I_data;
   logic [2:0]               I_selMem;
   logic                     O_full;
   logic                     O_empty;
   logic [$clog2(DEPTH):0]   O_count;
   logic                     O_memValid;
   logic [13:0]              O_memAddr;
   logic [31:0]              O_memData;
   logic [3:0]               O_memWe;
   logic                     I_memReady;

   modport slave (
      input  I_valid, I_addr, I_data, I_selMem, I_memReady,
      output O_full, O_empty, O_count, O_memValid, O_memAddr, O_memData, O_memWe
   );

   modport master (
      output I_valid, I_addr, I_data, I_selMem, I_memReady,
      input  O_full, O_empty, O_count, O_memValid, O_memAddr, O_memData, O_memWe
   );
endinterface

// File: rtl/ceespu_store_queue.sv
// Store queue: lane-formats execute-stage stores on entry and drains them to data memory.
// Define CEESPU_STORE_MERGE_EN to merge same-address stores into the (non-head) tail entry.
module ceespu_store_queue #(
   parameter int DEPTH = 4
) (
   input logic                 I_clk,
   input logic                 I_rst,
   ceespu_store_queue_if.slave sq
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [13:0] addr;
      logic [31:0] data;
      logic [3:0]  we;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        new_entry;
   entry_t        head_entry;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, empty_q;
   logic          push, pop, alloc, merge;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      new_entry.addr = sq.I_addr;
      new_entry.data = sq.I_data;
      new_entry.we   = 4'b1111;
      case (sq.I_selMem) inside
         3'b010: begin
            new_entry.we   = 4'b0011;
            new_entry.data = {2{sq.I_data[15:0]}};
         end
         3'b011: begin
            new_entry.we   = 4'b1100;
            new_entry.data = {2{sq.I_data[15:0]}};
         end
         3'b1??: begin
            new_entry.we   = 4'b0001 << sq.I_selMem[1:0];
            new_entry.data = {4{sq.I_data[7:0]}};
         end
         default: ;
      endcase
   end

   assign push = sq.I_valid & ~full_q;
   assign pop  = ~empty_q & sq.I_memReady;

`ifdef CEESPU_STORE_MERGE_EN
   logic [PW-1:0] last_idx;
   entry_t        merged_entry;

   // count >= 2 keeps the merge target away from the head, which may be on the bus.
   assign last_idx = tail_q - 1'b1;
   assign merge    = push && (count_q >= CW'(2)) && (sq.I_addr == mem_q[last_idx].addr);

   always_comb begin
      merged_entry      = mem_q[last_idx];
      merged_entry.we   = mem_q[last_idx].we | new_entry.we;
      for (int k = 0; k < 4; k++) begin
         if (new_entry.we[k]) merged_entry.data[8*k +: 8] = new_entry.data[8*k +: 8];
      end
   end
`else
   assign merge = 1'b0;
`endif

   assign alloc = push & ~merge;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop)   head_d = head_q + 1'b1;
      if (alloc) tail_d = tail_q + 1'b1;
      case ({alloc, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge I_clk or negedge I_rst) begin
      if (!I_rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         // NOTE: state registers use non-blocking assignments so all flops update together.
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   // NOTE: entry storage is not reset; the head view below is masked while empty instead.
   always_ff @(posedge I_clk) begin
      if (alloc) mem_q[tail_q] <= new_entry;
`ifdef CEESPU_STORE_MERGE_EN
      if (merge) mem_q[last_idx] <= merged_entry;
`endif
   end

   assign head_entry    = empty_q ? '0 : mem_q[head_q];

   assign sq.O_full     = full_q;
   assign sq.O_empty    = empty_q;
   assign sq.O_count    = count_q;
   assign sq.O_memValid = ~empty_q;
   assign sq.O_memAddr  = head_entry.addr;
   assign sq.O_memData  = head_entry.data;
   assign sq.O_memWe    = head_entry.we;
endmodule

// File: tb/tb_ceespu_store_queue.sv
// Scoreboard bench for ceespu_store_queue: directed stores push hand-computed entries,
// a negedge monitor compares status and the head entry and pops on each accepted transfer.
`timescale 1ns/1ps
module tb_ceespu_store_queue;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [13:0] addr;
      logic [31:0] data;
      logic [3:0]  we;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   model_count = 0;
   bit   mon_en = 1'b0;
   exp_t exp_q[$];

   ceespu_store_queue_if #(.DEPTH(DEPTH)) sq ();

   ceespu_store_queue #(.DEPTH(DEPTH)) dut (
      .I_clk (clk),
      .I_rst (rst_n),
      .sq    (sq.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: status against the model count, head entry against the scoreboard front.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("count", 32'(sq.O_count), 32'(model_count));
            check("full", 32'(sq.O_full), 32'(model_count == DEPTH));
            check("empty", 32'(sq.O_empty), 32'(model_count == 0));
            check("mem_valid", 32'(sq.O_memValid), 32'(model_count != 0));
            if (sq.O_memValid) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_entry: got addr 0x%0h data 0x%0h, expected none",
                           sq.O_memAddr, sq.O_memData);
               end else begin
                  check("mem_addr", 32'(sq.O_memAddr), 32'(exp_q[0].addr));
                  check("mem_data", sq.O_memData, exp_q[0].data);
                  check("mem_we", 32'(sq.O_memWe), 32'(exp_q[0].we));
                  if (sq.I_memReady) void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // One clock of stimulus; scoreboard/model updates land just after the edge.
   task automatic drive(input logic v, input logic [13:0] a, input logic [31:0] d,
                        input logic [2:0] sel, input logic rdy,
                        input logic [31:0] xd, input logic [3:0] xwe, input bit mrg);
      bit   acc;
      bit   pop;
      exp_t e;
      sq.I_valid    = v;
      sq.I_addr     = a;
      sq.I_data     = d;
      sq.I_selMem   = sel;
      sq.I_memReady = rdy;
      acc = v && (model_count < DEPTH);
      pop = (model_count > 0) && rdy;
      @(posedge clk);
      #1;
      e.addr = a;
      e.data = xd;
      e.we   = xwe;
      if (acc && mrg) exp_q[exp_q.size()-1] = e;
      else if (acc) exp_q.push_back(e);
      model_count = model_count + ((acc && !mrg) ? 1 : 0) - (pop ? 1 : 0);
   endtask

   task automatic store(input logic [13:0] a, input logic [31:0] d, input logic [2:0] sel,
                        input logic [31:0] xd, input logic [3:0] xwe, input logic rdy);
      drive(1'b1, a, d, sel, rdy, xd, xwe, 1'b0);
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, rdy, '0, '0, 1'b0);
   endtask

   initial begin
      sq.I_valid    = 1'b0;
      sq.I_addr     = '0;
      sq.I_data     = '0;
      sq.I_selMem   = '0;
      sq.I_memReady = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_mem_valid", 32'(sq.O_memValid), 32'd0);
      check("rst_empty", 32'(sq.O_empty), 32'd1);
      check("rst_full", 32'(sq.O_full), 32'd0);
      check("rst_count", 32'(sq.O_count), 32'd0);
      check("rst_mem_addr", 32'(sq.O_memAddr), 32'd0);
      check("rst_mem_data", sq.O_memData, 32'd0);
      check("rst_mem_we", 32'(sq.O_memWe), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Single byte store, drained the cycle after acceptance
      store(14'h0010, 32'h0000_00AB, 3'b110, 32'hABAB_ABAB, 4'b0100, 1'b1);
      idle(1'b1, 2);

      // Fill to DEPTH under stall, reject while full, then drain in order
      for (int i = 1; i <= DEPTH; i++)
         store(14'(16'h0040 + i), 32'(i), 3'b000, 32'(i), 4'b1111, 1'b0);
      idle(1'b0, 2);
      store(14'h0050, 32'd5, 3'b000, 32'd5, 4'b1111, 1'b0);
      store(14'h0051, 32'd6, 3'b000, 32'd6, 4'b1111, 1'b1);
      idle(1'b1, 5);

      // Occupancy 2 with simultaneous enqueue/dequeue across pointer wrap
      store(14'h0060, 32'h60, 3'b000, 32'h60, 4'b1111, 1'b0);
      store(14'h0061, 32'h61, 3'b000, 32'h61, 4'b1111, 1'b0);
      for (int i = 0; i < 10; i++)
         store(14'(16'h0070 + i), 32'(32'h700 + i), 3'b000, 32'(32'h700 + i), 4'b1111, 1'b1);
      idle(1'b1, 4);

      // Asynchronous reset during a stalled transfer
      store(14'h0080, 32'hA1, 3'b000, 32'hA1, 4'b1111, 1'b0);
      store(14'h0081, 32'hA2, 3'b000, 32'hA2, 4'b1111, 1'b0);
      store(14'h0082, 32'hA3, 3'b000, 32'hA3, 4'b1111, 1'b0);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("async_rst_mem_valid", 32'(sq.O_memValid), 32'd0);
      check("async_rst_count", 32'(sq.O_count), 32'd0);
      check("async_rst_empty", 32'(sq.O_empty), 32'd1);
      exp_q.delete();
      model_count = 0;
      sq.I_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      check("post_rst_mem_data", sq.O_memData, 32'd0);
      check("post_rst_mem_we", 32'(sq.O_memWe), 32'd0);
      idle(1'b1, 2);

      // Same-address stores behind a pending head
      store(14'h0020, 32'h0000_000A, 3'b000, 32'h0000_000A, 4'b1111, 1'b0);
      store(14'h0021, 32'h0000_0011, 3'b100, 32'h1111_1111, 4'b0001, 1'b0);
`ifdef CEESPU_STORE_MERGE_EN
      drive(1'b1, 14'h0021, 32'h0000_0022, 3'b101, 1'b0, 32'h1111_2211, 4'b0011, 1'b1);
      check("merge_count", 32'(sq.O_count), 32'd2);
`else
      store(14'h0021, 32'h0000_0022, 3'b101, 32'h2222_2222, 4'b0010, 1'b0);
      check("merge_count", 32'(sq.O_count), 32'd3);
`endif
      idle(1'b1, 5);

      // Lane formatting for the remaining select encodings
      store(14'h0030, 32'h0000_1234, 3'b011, 32'h1234_1234, 4'b1100, 1'b1);
      store(14'h0031, 32'hFFFF_1234, 3'b010, 32'h1234_1234, 4'b0011, 1'b1);
      store(14'h0032, 32'hDEAD_BEEF, 3'b001, 32'hDEAD_BEEF, 4'b1111, 1'b1);
      store(14'h0033, 32'h1234_565A, 3'b111, 32'h5A5A_5A5A, 4'b1000, 1'b1);
      idle(1'b1, 3);

      mon_en = 1'b0;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
